// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: PC, next-PC selection, fetch latch
// under hazard-unit stall/flush control, plus debug event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             if_id_flush,
    input  logic [1:0]       s_npc,
    input  logic             zero,
    input  logic [31:0]      rs_data_id,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      pc_id,
    output logic [31:0]      pc4_id,
    output logic [31:0]      instr_id,
    output logic             valid_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);
    localparam logic [1:0]       PC_4   = 2'b00;
    localparam logic [1:0]       PC_BEQ = 2'b01;
    localparam logic [1:0]       PC_J   = 2'b10;
    localparam logic [1:0]       PC_JR  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]        r_pc;
    logic [31:0]        r_pc_id;
    logic [31:0]        r_instr_id;
    logic               r_valid_id;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   r_redirect_cnt;

    logic [31:0]        w_pc4;
    logic [31:0]        w_pc4_id;
    logic signed [31:0] w_br_off;
    logic [31:0]        w_next_pc;
    logic               w_redirect;

    assign w_pc4    = r_pc + 32'd4;
    assign w_pc4_id = r_pc_id + 32'd4;
    // Word offset from the branch immediate, sign-extended then scaled by 4.
    assign w_br_off = $signed({{14{r_instr_id[15]}}, r_instr_id[15:0], 2'b00});

    always_comb begin
        w_next_pc  = w_pc4;
        w_redirect = 1'b0;
        case (s_npc)
            PC_4: begin
                w_next_pc  = w_pc4;
                w_redirect = 1'b0;
            end
            PC_BEQ: begin
                if (zero) begin
                    w_next_pc  = w_pc4_id + $unsigned(w_br_off);
                    w_redirect = 1'b1;
                end
            end
            PC_J: begin
                w_next_pc  = {w_pc4_id[31:28], r_instr_id[25:0], 2'b00};
                w_redirect = 1'b1;
            end
            PC_JR: begin
                w_next_pc  = rs_data_id;
                w_redirect = 1'b1;
            end
            default: begin
                w_next_pc  = w_pc4;
                w_redirect = 1'b0;
            end
        endcase
    end

    // Stall and flush together leave the PC parked, so the held PC is re-fetched
    // into the bubble slot next cycle and nothing is duplicated.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc           <= RESET_PC;
            r_pc_id        <= 32'd0;
            r_instr_id     <= 32'd0;
            r_valid_id     <= 1'b0;
            r_stall_cnt    <= '0;
            r_flush_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (pc_write)
                r_pc <= w_next_pc;

            if (if_id_flush) begin
                r_instr_id <= 32'd0;
                r_pc_id    <= 32'd0;
                r_valid_id <= 1'b0;
            end else if (if_id_write) begin
                r_instr_id <= imem_rdata;
                r_pc_id    <= r_pc;
                r_valid_id <= 1'b1;
            end

            if (!pc_write)
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (if_id_flush)
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            if (w_redirect)
                r_redirect_cnt <= r_redirect_cnt + CNT_ONE;
        end
    end

    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign pc_id        = r_pc_id;
    assign pc4_id       = w_pc4_id;
    assign instr_id     = r_instr_id;
    assign valid_id     = r_valid_id;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign redirect_cnt = r_redirect_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural model pushes expected state per
// cycle into a scoreboard queue, popped and compared one cycle later.
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pc_write = 1'b1;
    logic        if_id_write = 1'b1;
    logic        if_id_flush = 1'b0;
    logic [1:0]  s_npc = 2'b00;
    logic        zero = 1'b0;
    logic [31:0] rs_data_id = 32'd0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] imem_addr, pc, pc_id, pc4_id, instr_id;
    logic        valid_id;
    logic [15:0] stall_cnt, flush_cnt, redirect_cnt;

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .s_npc(s_npc), .zero(zero), .rs_data_id(rs_data_id),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc), .pc_id(pc_id),
        .pc4_id(pc4_id), .instr_id(instr_id), .valid_id(valid_id),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .redirect_cnt(redirect_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_id;
        logic [31:0] instr;
        logic        valid;
        logic [15:0] st;
        logic [15:0] fl;
        logic [15:0] rd;
    } exp_t;

    exp_t sb[$];

    // Model state
    logic [31:0] m_pc = 32'd0, m_pc_id = 32'd0, m_instr = 32'd0;
    logic        m_valid = 1'b0;
    logic [15:0] m_st = 16'd0, m_fl = 16'd0, m_rd = 16'd0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model the next edge, push expectation, clock, then pop and compare.
    task automatic step();
        logic [31:0] npc, pc4i;
        logic        redir;
        exp_t        e, g;
        pc4i  = m_pc_id + 32'd4;
        npc   = m_pc + 32'd4;
        redir = 1'b0;
        if (s_npc == 2'b01 && zero) begin
            npc = pc4i + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
            redir = 1'b1;
        end else if (s_npc == 2'b10) begin
            npc = {pc4i[31:28], m_instr[25:0], 2'b00};
            redir = 1'b1;
        end else if (s_npc == 2'b11) begin
            npc = rs_data_id;
            redir = 1'b1;
        end
        if (!reset) begin
            m_pc = 32'd0; m_pc_id = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
            m_st = 16'd0; m_fl = 16'd0; m_rd = 16'd0;
        end else begin
            if (!pc_write) m_st = m_st + 16'd1;
            if (if_id_flush) m_fl = m_fl + 16'd1;
            if (redir) m_rd = m_rd + 16'd1;
            if (if_id_flush) begin
                m_instr = 32'd0; m_pc_id = 32'd0; m_valid = 1'b0;
            end else if (if_id_write) begin
                m_instr = imem_rdata; m_pc_id = m_pc; m_valid = 1'b1;
            end
            if (pc_write) m_pc = npc;
        end
        e = '{pc: m_pc, pc_id: m_pc_id, instr: m_instr, valid: m_valid,
              st: m_st, fl: m_fl, rd: m_rd};
        sb.push_back(e);
        @(posedge clock);
        #1;
        g = sb.pop_front();
        chk("pc", pc, g.pc);
        chk("imem_addr", imem_addr, g.pc);
        chk("pc_id", pc_id, g.pc_id);
        chk("pc4_id", pc4_id, g.pc_id + 32'd4);
        chk("instr_id", instr_id, g.instr);
        chk("valid_id", {31'd0, valid_id}, {31'd0, g.valid});
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, g.st});
        chk("flush_cnt", {16'd0, flush_cnt}, {16'd0, g.fl});
        chk("redirect_cnt", {16'd0, redirect_cnt}, {16'd0, g.rd});
    endtask

    // Fetch memory contents: word tagged with its own address.
    task automatic fetch_default();
        imem_rdata = m_pc | 32'hA000_0000;
    endtask

    task automatic normal();
        pc_write = 1'b1; if_id_write = 1'b1; if_id_flush = 1'b0;
        s_npc = 2'b00; zero = 1'b0;
    endtask

    initial begin
        // Reset held
        reset = 1'b0; normal(); fetch_default();
        @(negedge clock);
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, valid_id}, 32'd0);

        // Free-running fetch
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_default();
            step();
            if (i == 0) chk("first_instr", instr_id, 32'hA000_0000);
            if (i == 1) chk("second_instr", instr_id, 32'hA000_0004);
        end
        chk("run_pc", pc, 32'h10);
        chk("run_cnts", {stall_cnt, flush_cnt}, 32'h0);

        // Load-use stall
        pc_write = 1'b0; if_id_write = 1'b0; fetch_default();
        step();
        chk("stall_pc", pc, 32'h10);
        chk("stall_instr", instr_id, 32'hA000_000C);
        chk("stall_cnt1", {16'd0, stall_cnt}, 32'd1);
        normal(); fetch_default(); step();
        chk("post_stall_pc", pc, 32'h14);

        // Walk to 0x20, then load a BEQ word into IF/ID
        for (int i = 0; i < 3; i++) begin
            fetch_default(); step();
        end
        imem_rdata = 32'h1000_0003; step();
        chk("beq_in_id", instr_id, 32'h1000_0003);
        chk("beq_pc_id", pc_id, 32'h20);

        // Taken BEQ with flush
        s_npc = 2'b01; zero = 1'b1; if_id_flush = 1'b1; fetch_default(); step();
        chk("beq_taken_pc", pc, 32'h30);
        chk("beq_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("beq_redir_cnt", {16'd0, redirect_cnt}, 32'd1);

        // Not-taken BEQ
        normal(); s_npc = 2'b01; zero = 1'b0; fetch_default(); step();
        chk("beq_nt_pc", pc, 32'h34);
        chk("beq_nt_instr", instr_id, 32'hA000_0030);
        chk("beq_nt_redir", {16'd0, redirect_cnt}, 32'd1);

        // JR to 0x4000_0008, load J word there, then take J
        normal(); s_npc = 2'b11; rs_data_id = 32'h4000_0008; fetch_default(); step();
        chk("jr1_pc", pc, 32'h4000_0008);
        normal(); imem_rdata = 32'h0800_0100; step();
        s_npc = 2'b10; if_id_flush = 1'b1; fetch_default(); step();
        chk("j_pc", pc, 32'h4000_0400);

        // JR
        normal(); s_npc = 2'b11; rs_data_id = 32'h1234_5678; fetch_default(); step();
        chk("jr_pc", pc, 32'h1234_5678);

        // Wrap 0xFFFF_FFFC -> 0
        rs_data_id = 32'hFFFF_FFFC; fetch_default(); step();
        normal(); fetch_default(); step();
        chk("wrap_pc", pc, 32'h0);

        // Stall and flush together
        pc_write = 1'b0; if_id_flush = 1'b1; s_npc = 2'b10; fetch_default(); step();
        chk("sf_pc", pc, 32'h0);
        chk("sf_valid", {31'd0, valid_id}, 32'd0);

        // Reset mid-stall
        reset = 1'b0; step();
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_cnts", {stall_cnt, redirect_cnt}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
